// File: rtl/fabric_cfg_pkg.sv
// Shared fabric configuration types: loader FSM states and tile chain sizing.
// Pure declarations; no timing or flow control of its own.
package fabric_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } cfg_state_e;

  localparam int CB_CONFIG_BITS = 4;
  localparam int SB_CONFIG_BITS = 8;

  // Scan chain bits contributed by one tile with the given block counts.
  function automatic int tile_chain_bits(input int n_cb, input int n_sb);
    return n_cb * CB_CONFIG_BITS + n_sb * SB_CONFIG_BITS;
  endfunction

endpackage

// File: rtl/scan_config_loader_piso_buffer.sv
// Parallel-in/serial-out word buffer with a down-counter of bits still to send; ser_dat is valid the cycle after load.
// No backpressure: shift advances one bit per cycle while the counter is non-zero.
module piso_buffer
  import fabric_cfg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_dat,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             shift,
  output logic             ser_dat,
  output logic             last,
  output logic             empty
);

  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      cnt  <= '0;
    end else if (load) begin
      data <= load_dat;
      cnt  <= load_cnt;
    end else if (shift && !empty) begin
      data <= data >> 1;
      cnt  <= cnt - CNT_W'(1);
    end
  end

  assign ser_dat = data[0];
  assign last    = (cnt == CNT_W'(1));
  assign empty   = (cnt == '0);

endmodule

// File: rtl/scan_config_loader.sv
// Serialises host words LSB-first onto the fabric scan chain and captures readback; each full word costs WORD_WIDTH+1 cycles.
// Backpressure: word_ready only in LOAD; rb_word/rb_valid and done are unconditioned pulses.
module scan_config_loader
  import fabric_cfg_pkg::*;
#(
  parameter int CHAIN_LENGTH = CB_CONFIG_BITS,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  scan_en,
  output logic                  scan_in,
  input  logic                  chain_out,
  output logic [WORD_WIDTH-1:0] rb_word,
  output logic                  rb_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int BCW = $clog2(CHAIN_LENGTH + 1);
  localparam int WCW = $clog2(WORD_WIDTH + 1);
  localparam int IW  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  cfg_state_e            state;
  logic [BCW-1:0]        bits_shifted;
  logic [IW-1:0]         bit_idx;
  logic [WORD_WIDTH-1:0] rb_acc;
  logic [WORD_WIDTH-1:0] rb_next;
  logic [WCW-1:0]        load_cnt;
  int                    bits_left;
  logic                  word_hs;
  logic                  piso_ser;
  logic                  piso_last;
  logic                  piso_empty;

  assign word_ready = (state == LOAD);
  assign word_hs    = word_valid && word_ready;

  // Last word of the stream only carries the bits that still fit in the chain.
  always_comb begin
    bits_left = CHAIN_LENGTH - int'(bits_shifted);
    load_cnt  = (bits_left > WORD_WIDTH) ? WCW'(WORD_WIDTH) : WCW'(bits_left);
  end

  always_comb begin
    rb_next          = rb_acc;
    rb_next[bit_idx] = chain_out;
  end

  piso_buffer #(
    .WIDTH (WORD_WIDTH),
    .CNT_W (WCW)
  ) u_piso (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (word_hs),
    .load_dat (word_in),
    .load_cnt (load_cnt),
    .shift    (scan_en),
    .ser_dat  (piso_ser),
    .last     (piso_last),
    .empty    (piso_empty)
  );

  assign scan_in = scan_en & piso_ser;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bits_shifted <= '0;
      bit_idx      <= '0;
      rb_acc       <= '0;
      rb_word      <= '0;
      rb_valid     <= 1'b0;
      scan_en      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= LOAD;
            busy         <= 1'b1;
            bits_shifted <= '0;
          end
        end
        LOAD: begin
          if (word_valid) begin
            state   <= SHIFT;
            scan_en <= 1'b1;
            bit_idx <= '0;
            rb_acc  <= '0;
          end
        end
        SHIFT: begin
          if (!piso_empty) begin
            bits_shifted <= bits_shifted + BCW'(1);
            bit_idx      <= bit_idx + IW'(1);
            rb_acc       <= rb_next;
            if (piso_last) begin
              rb_word  <= rb_next;
              rb_valid <= 1'b1;
              scan_en  <= 1'b0;
              if (bits_shifted + BCW'(1) == BCW'(CHAIN_LENGTH)) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= LOAD;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_config_loader.sv
// Bench for scan_config_loader at CHAIN_LENGTH 4 and 12 with a behavioural fabric chain model.
module tb_scan_config_loader;

  localparam int W   = 8;
  localparam int CL0 = 4;
  localparam int CL1 = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] start_s, word_valid_s, word_ready_s, scan_en_s, scan_in_s;
  logic [1:0] chain_out_s, rb_valid_s, busy_s, done_s;
  logic [W-1:0] word_in_s [2];
  logic [W-1:0] rb_word_s [2];
  logic [11:0]  chain [2] = '{12'h000, 12'h000};
  int hs_cnt [2] = '{0, 0};
  int passed = 0;
  int total  = 0;

  scan_config_loader #(.CHAIN_LENGTH(CL0), .WORD_WIDTH(W)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .word_in(word_in_s[0]),
    .word_valid(word_valid_s[0]), .word_ready(word_ready_s[0]), .scan_en(scan_en_s[0]),
    .scan_in(scan_in_s[0]), .chain_out(chain_out_s[0]), .rb_word(rb_word_s[0]),
    .rb_valid(rb_valid_s[0]), .busy(busy_s[0]), .done(done_s[0])
  );

  scan_config_loader #(.CHAIN_LENGTH(CL1), .WORD_WIDTH(W)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .word_in(word_in_s[1]),
    .word_valid(word_valid_s[1]), .word_ready(word_ready_s[1]), .scan_en(scan_en_s[1]),
    .scan_in(scan_in_s[1]), .chain_out(chain_out_s[1]), .rb_word(rb_word_s[1]),
    .rb_valid(rb_valid_s[1]), .busy(busy_s[1]), .done(done_s[1])
  );

  function automatic int cl_of(input int u);
    return (u == 0) ? CL0 : CL1;
  endfunction

  // Fabric chain: new bit enters at the far end, chain_out is bit 0.
  assign chain_out_s[0] = chain[0][0];
  assign chain_out_s[1] = chain[1][0];

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (scan_en_s[u])
        chain[u] <= (chain[u] >> 1) | (12'(scan_in_s[u]) << (cl_of(u) - 1));
      if (word_valid_s[u] && word_ready_s[u])
        hs_cnt[u] = hs_cnt[u] + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic run_load(input int u, input logic [15:0] words, input int dly,
                          input bit hold, input bit poke, input int abort_at,
                          input logic [15:0] exp_rb, input logic [11:0] exp_cfg);
    int cl;
    int nw;
    int k;
    int b;
    int hs0;
    cl  = cl_of(u);
    nw  = (cl + W - 1) / W;
    k   = 0;
    hs0 = hs_cnt[u];
    @(negedge clk); start_s[u] = 1'b1;
    @(negedge clk); start_s[u] = 1'b0;
    chk("busy_after_start", busy_s[u], 1);
    chk("ready_in_load", word_ready_s[u], 1);
    for (int n = 0; n < nw; n++) begin
      b = (cl - k > W) ? W : cl - k;
      if (n == 0) begin
        for (int d = 0; d < dly; d++) begin
          chk("wait_scan_en_low", scan_en_s[u], 0);
          chk("wait_ready_high", word_ready_s[u], 1);
          @(negedge clk);
        end
      end
      word_in_s[u]    = words[n*W +: W];
      word_valid_s[u] = 1'b1;
      @(negedge clk);
      if (!hold) word_valid_s[u] = 1'b0;
      for (int j = 0; j < b; j++) begin
        if (k == abort_at) begin
          rst_n = 1'b0;
          #1;
          chk("abort_scan_en", scan_en_s[u], 0);
          chk("abort_busy", busy_s[u], 0);
          chk("abort_scan_in", scan_in_s[u], 0);
          word_valid_s[u] = 1'b0;
          @(negedge clk);
          chk("abort_no_done", done_s[u], 0);
          rst_n = 1'b1;
          @(negedge clk);
          chk("abort_idle_busy", busy_s[u], 0);
          chk("abort_idle_done", done_s[u], 0);
          return;
        end
        chk("shift_scan_en", scan_en_s[u], 1);
        chk("shift_bit", scan_in_s[u], words[k]);
        chk("shift_not_ready", word_ready_s[u], 0);
        if (poke && j == 1) start_s[u] = 1'b1;
        @(negedge clk);
        start_s[u] = 1'b0;
        k++;
      end
      word_valid_s[u] = 1'b0;
      chk("rb_valid", rb_valid_s[u], 1);
      chk("rb_word", rb_word_s[u], exp_rb[n*W +: W]);
      chk("done_at_word_end", done_s[u], (n == nw - 1));
      chk("busy_at_word_end", busy_s[u], 1);
    end
    @(negedge clk);
    chk("idle_busy", busy_s[u], 0);
    chk("idle_done", done_s[u], 0);
    chk("idle_rb_valid", rb_valid_s[u], 0);
    chk("chain_config", chain[u], exp_cfg);
    chk("word_handshakes", hs_cnt[u] - hs0, nw);
  endtask

  typedef struct {
    int          u;
    logic [15:0] words;
    int          dly;
    bit          hold;
    bit          poke;
    logic [15:0] exp_rb;
    logic [11:0] exp_cfg;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          u;
    int          cl;
    logic [15:0] words;
    logic [15:0] mask;

    vecs[0] = '{0, 16'h000B, 0, 1'b0, 1'b0, 16'h0000, 12'h00B};
    vecs[1] = '{0, 16'h0005, 0, 1'b0, 1'b0, 16'h000B, 12'h005};
    vecs[2] = '{0, 16'h000B, 5, 1'b0, 1'b0, 16'h0005, 12'h00B};
    vecs[3] = '{0, 16'h0006, 0, 1'b1, 1'b1, 16'h000B, 12'h006};
    vecs[4] = '{0, 16'h00F9, 1, 1'b0, 1'b0, 16'h0006, 12'h009};
    vecs[5] = '{1, 16'hF3A5, 0, 1'b0, 1'b0, 16'h0000, 12'h3A5};
    vecs[6] = '{1, 16'h1234, 2, 1'b1, 1'b1, 16'h03A5, 12'h234};

    rst_n        = 1'b0;
    start_s      = 2'b00;
    word_valid_s = 2'b00;
    word_in_s[0] = '0;
    word_in_s[1] = '0;
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("rst_scan_en", scan_en_s[i], 0);
      chk("rst_word_ready", word_ready_s[i], 0);
      chk("rst_rb_valid", rb_valid_s[i], 0);
      chk("rst_busy", busy_s[i], 0);
      chk("rst_done", done_s[i], 0);
      chk("rst_scan_in", scan_in_s[i], 0);
      chk("rst_rb_word", rb_word_s[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_load(vecs[i].u, vecs[i].words, vecs[i].dly, vecs[i].hold, vecs[i].poke, -1,
               vecs[i].exp_rb, vecs[i].exp_cfg);

    // Reset during the second shift cycle, then a fresh load must still work.
    run_load(0, 16'h000D, 0, 1'b0, 1'b0, 1, 16'h0000, 12'h000);

    for (int i = 0; i < 24; i++) begin
      u     = (i == 0) ? 0 : int'($urandom_range(0, 1));
      cl    = cl_of(u);
      words = 16'($urandom);
      mask  = 16'((32'd1 << cl) - 32'd1);
      run_load(u, words, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), -1, 16'(chain[u]) & mask, 12'(words & mask));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
